// File: rtl/riscv_pkg.sv
// Shared fetch-side types and constants: PC increment, BTB counter states,
// and the BTB entry layout sized for the widest supported XLEN.
package riscv_pkg;
  localparam int XLEN_MAX = 64;
  localparam int PC_INC   = 4;

  localparam logic [1:0] SNT = 2'd0;
  localparam logic [1:0] WNT = 2'd1;
  localparam logic [1:0] WT  = 2'd2;
  localparam logic [1:0] ST  = 2'd3;

  // Tag/target are stored zero-extended; narrower XLEN leaves the upper bits at 0.
  typedef struct packed {
    logic                  valid;
    logic [XLEN_MAX-1:0]   tag;
    logic [XLEN_MAX-3:0]   target;
    logic [1:0]            ctr;
  } btb_entry_t;

  function automatic logic [1:0] ctr_next(input logic [1:0] c, input logic taken);
    case (c)
      SNT:     return taken ? WNT : SNT;
      WNT:     return taken ? WT  : SNT;
      WT:      return taken ? ST  : WNT;
      default: return taken ? ST  : WT;
    endcase
  endfunction
endpackage

// File: rtl/pc_btb.sv
// Direct-mapped branch target buffer: combinational lookup on the fetch PC,
// edge-triggered update from resolved branches (lookup sees pre-update state).
module pc_btb
  import riscv_pkg::*;
#(
  parameter int XLEN  = 32,
  parameter int DEPTH = 8
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [XLEN-1:0] lookup_pc,
  output logic            hit_taken,
  output logic [XLEN-1:0] pred_target,
  input  logic            upd_en,
  input  logic [XLEN-1:0] upd_pc,
  input  logic [XLEN-1:0] upd_target,
  input  logic            upd_taken
);
  localparam int IDX = $clog2(DEPTH);

  btb_entry_t            tbl [DEPTH];
  btb_entry_t            l_ent;
  logic [IDX-1:0]        l_idx, u_idx;
  logic [XLEN_MAX-1:0]   l_tag, u_tag;
  logic [XLEN_MAX-3:0]   u_tgt;
  logic                  u_hit;
  logic                  unused_lsb;

  assign l_idx = lookup_pc[IDX+1:2];
  assign l_tag = XLEN_MAX'(lookup_pc[XLEN-1:IDX+2]);
  assign u_idx = upd_pc[IDX+1:2];
  assign u_tag = XLEN_MAX'(upd_pc[XLEN-1:IDX+2]);
  assign u_tgt = (XLEN_MAX-2)'(upd_target[XLEN-1:2]);
  assign unused_lsb = ^{lookup_pc[1:0], upd_pc[1:0], upd_target[1:0]};

  assign l_ent       = tbl[l_idx];
  assign hit_taken   = l_ent.valid && (l_ent.tag == l_tag) && l_ent.ctr[1];
  assign pred_target = XLEN'({l_ent.target, 2'b00});
  assign u_hit       = tbl[u_idx].valid && (tbl[u_idx].tag == u_tag);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) tbl[i] <= '0;
    end else if (upd_en) begin
      if (u_hit) begin
        tbl[u_idx].ctr <= ctr_next(tbl[u_idx].ctr, upd_taken);
        if (upd_taken) tbl[u_idx].target <= u_tgt;
      end else if (upd_taken) begin
        tbl[u_idx] <= '{valid: 1'b1, tag: u_tag, target: u_tgt, ctr: WT};
      end
    end
  end
endmodule

// File: rtl/pc_gen.sv
// Fetch PC register with trap > jump > accepted-fetch priority and an optional
// BTB steering the sequential path.
module pc_gen
  import riscv_pkg::*;
#(
  parameter int              XLEN       = 32,
  parameter logic [XLEN-1:0] RESET_ADDR = '0,
  parameter bit              BTB_EN     = 1'b1,
  parameter int              BTB_DEPTH  = 8
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            trap_en_i,
  input  logic [XLEN-1:0] trap_addr_i,
  input  logic            jump_en_i,
  input  logic [XLEN-1:0] jump_addr_i,
  input  logic            upd_en_i,
  input  logic [XLEN-1:0] upd_pc_i,
  input  logic [XLEN-1:0] upd_target_i,
  input  logic            upd_taken_i,
  output logic            pc_valid_o,
  input  logic            pc_ready_i,
  output logic [XLEN-1:0] pc_addr_o,
  output logic            pc_pred_o,
  output logic            misalign_o
);
  logic            hit_taken;
  logic [XLEN-1:0] pred_target;
  logic [XLEN-1:0] pc_d;
  logic            mis_d;

  if (BTB_EN) begin : g_btb
    pc_btb #(.XLEN(XLEN), .DEPTH(BTB_DEPTH)) u_btb (
      .clk         (clk),
      .rst         (rst),
      .lookup_pc   (pc_addr_o),
      .hit_taken   (hit_taken),
      .pred_target (pred_target),
      .upd_en      (upd_en_i),
      .upd_pc      (upd_pc_i),
      .upd_target  (upd_target_i),
      .upd_taken   (upd_taken_i)
    );
  end else begin : g_no_btb
    logic unused_upd;
    assign unused_upd  = ^{upd_en_i, upd_pc_i, upd_target_i, upd_taken_i};
    assign hit_taken   = 1'b0;
    assign pred_target = '0;
  end

  assign pc_pred_o = hit_taken & pc_valid_o;

  always_comb begin
    pc_d  = pc_addr_o;
    mis_d = 1'b0;
    if (trap_en_i) begin
      pc_d  = {trap_addr_i[XLEN-1:2], 2'b00};
      mis_d = |trap_addr_i[1:0];
    end else if (jump_en_i) begin
      pc_d  = {jump_addr_i[XLEN-1:2], 2'b00};
      mis_d = |jump_addr_i[1:0];
    end else if (pc_valid_o && pc_ready_i) begin
      pc_d = pc_pred_o ? pred_target : pc_addr_o + XLEN'(PC_INC);
    end
  end

  // Valid rises on the first edge out of reset and never drops until the next reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pc_addr_o  <= RESET_ADDR;
      pc_valid_o <= 1'b0;
      misalign_o <= 1'b0;
    end else begin
      pc_addr_o  <= pc_d;
      pc_valid_o <= 1'b1;
      misalign_o <= mis_d;
    end
  end
endmodule

// File: tb/tb_pc_gen.sv
// Directed bench for pc_gen: a BTB-enabled 32-bit instance and a BTB-less
// 64-bit instance, checked against a queue of expected output snapshots.
module tb_pc_gen;
  logic        clk = 1'b0;
  logic        rst;
  logic        trap_en, jump_en, upd_en, upd_taken, pc_ready;
  logic [31:0] trap_addr, jump_addr, upd_pc, upd_target;
  logic        pc_valid, pc_pred, misalign;
  logic [31:0] pc_addr;

  logic        trap_en_w, jump_en_w, upd_en_w, upd_taken_w, pc_ready_w;
  logic [63:0] trap_addr_w, jump_addr_w, upd_pc_w, upd_target_w;
  logic        pc_valid_w, pc_pred_w, misalign_w;
  logic [63:0] pc_addr_w;

  typedef struct {
    string       name;
    logic [63:0] pc;
    logic        valid;
    logic        pred;
    logic        mis;
  } exp_t;

  exp_t sb32[$];
  exp_t sb64[$];
  int   n_tests = 0;
  int   n_fail  = 0;

  always #5 clk = ~clk;

  pc_gen #(.XLEN(32), .RESET_ADDR(32'h0), .BTB_EN(1'b1), .BTB_DEPTH(8)) dut (
    .clk(clk), .rst(rst),
    .trap_en_i(trap_en), .trap_addr_i(trap_addr),
    .jump_en_i(jump_en), .jump_addr_i(jump_addr),
    .upd_en_i(upd_en), .upd_pc_i(upd_pc), .upd_target_i(upd_target), .upd_taken_i(upd_taken),
    .pc_valid_o(pc_valid), .pc_ready_i(pc_ready), .pc_addr_o(pc_addr),
    .pc_pred_o(pc_pred), .misalign_o(misalign)
  );

  pc_gen #(.XLEN(64), .RESET_ADDR(64'h0), .BTB_EN(1'b0), .BTB_DEPTH(8)) dut_w (
    .clk(clk), .rst(rst),
    .trap_en_i(trap_en_w), .trap_addr_i(trap_addr_w),
    .jump_en_i(jump_en_w), .jump_addr_i(jump_addr_w),
    .upd_en_i(upd_en_w), .upd_pc_i(upd_pc_w), .upd_target_i(upd_target_w), .upd_taken_i(upd_taken_w),
    .pc_valid_o(pc_valid_w), .pc_ready_i(pc_ready_w), .pc_addr_o(pc_addr_w),
    .pc_pred_o(pc_pred_w), .misalign_o(misalign_w)
  );

  task automatic exp32(input string n, input logic [63:0] pc, input logic v, input logic p, input logic m);
    exp_t e;
    e.name = n; e.pc = pc; e.valid = v; e.pred = p; e.mis = m;
    sb32.push_back(e);
  endtask

  task automatic exp64(input string n, input logic [63:0] pc, input logic v, input logic p, input logic m);
    exp_t e;
    e.name = n; e.pc = pc; e.valid = v; e.pred = p; e.mis = m;
    sb64.push_back(e);
  endtask

  task automatic chk(input bit wide);
    exp_t        e;
    logic [66:0] obs, want;
    n_tests++;
    if ((wide ? sb64.size() : sb32.size()) == 0) begin
      n_fail++;
      $error("FAIL sb_empty: no expected entry queued");
      return;
    end
    e    = wide ? sb64.pop_front() : sb32.pop_front();
    obs  = wide ? {pc_addr_w, pc_valid_w, pc_pred_w, misalign_w}
                : {32'h0, pc_addr, pc_valid, pc_pred, misalign};
    want = {e.pc, e.valid, e.pred, e.mis};
    assert (obs === want) else begin
      n_fail++;
      $error("FAIL %s: got pc=%h v=%b p=%b m=%b, expected pc=%h v=%b p=%b m=%b",
             e.name, obs[66:3], obs[2], obs[1], obs[0], e.pc, e.valid, e.pred, e.mis);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    rst = 1'b1;
    trap_en = 0; jump_en = 0; upd_en = 0; upd_taken = 0; pc_ready = 0;
    trap_addr = 0; jump_addr = 0; upd_pc = 0; upd_target = 0;
    trap_en_w = 0; jump_en_w = 0; upd_en_w = 0; upd_taken_w = 0; pc_ready_w = 0;
    trap_addr_w = 0; jump_addr_w = 0; upd_pc_w = 0; upd_target_w = 0;

    #3;
    exp32("reset", 0, 0, 0, 0); chk(0);
    exp64("reset_w", 0, 0, 0, 0); chk(1);

    #4 rst = 1'b0; pc_ready = 1'b1;
    exp32("valid_rise", 0, 1, 0, 0); tick(); chk(0);
    for (int i = 1; i <= 4; i++) begin
      exp32("seq", 64'(i * 4), 1, 0, 0); tick(); chk(0);
    end

    pc_ready = 0;
    repeat (3) begin exp32("hold", 'h10, 1, 0, 0); tick(); chk(0); end

    jump_en = 1; jump_addr = 'h203;
    exp32("jump_mis", 'h200, 1, 0, 1); tick(); chk(0);
    jump_en = 0;
    exp32("mis_once", 'h200, 1, 0, 0); tick(); chk(0);

    trap_en = 1; trap_addr = 'h80; jump_en = 1; jump_addr = 'h400;
    exp32("trap_prio", 'h80, 1, 0, 0); tick(); chk(0);
    trap_en = 0; jump_en = 0;

    upd_en = 1; upd_pc = 'h10; upd_target = 'h100; upd_taken = 1;
    exp32("alloc", 'h80, 1, 0, 0); tick(); chk(0);
    upd_en = 0;
    jump_en = 1; jump_addr = 'h10;
    exp32("btb_hit", 'h10, 1, 1, 0); tick(); chk(0);
    jump_en = 0; pc_ready = 1;
    exp32("btb_tgt", 'h100, 1, 0, 0); tick(); chk(0);
    pc_ready = 0;

    upd_en = 1; upd_taken = 0;
    exp32("nt1", 'h100, 1, 0, 0); tick(); chk(0);
    exp32("nt2", 'h100, 1, 0, 0); tick(); chk(0);
    upd_en = 0;
    jump_en = 1; jump_addr = 'h10;
    exp32("btb_weak", 'h10, 1, 0, 0); tick(); chk(0);
    jump_en = 0; pc_ready = 1;
    exp32("seq_after_nt", 'h14, 1, 0, 0); tick(); chk(0);
    pc_ready = 0;

    // counter 0 -> 3 (saturating), then one not-taken leaves it predicting
    upd_en = 1; upd_taken = 1;
    repeat (4) begin exp32("train", 'h14, 1, 0, 0); tick(); chk(0); end
    upd_taken = 0;
    exp32("sat_nt", 'h14, 1, 0, 0); tick(); chk(0);
    upd_en = 0;
    jump_en = 1; jump_addr = 'h10;
    exp32("sat_pred", 'h10, 1, 1, 0); tick(); chk(0);
    jump_addr = 'h30;
    exp32("alias", 'h30, 1, 0, 0); tick(); chk(0);
    jump_en = 0; pc_ready = 1;
    exp32("alias_seq", 'h34, 1, 0, 0); tick(); chk(0);

    jump_en = 1; jump_addr = 'h44;
    exp32("jump_over_accept", 'h44, 1, 0, 0); tick(); chk(0);
    jump_en = 0; pc_ready = 0;

    #2 rst = 1'b1;
    #1 exp32("async_rst", 0, 0, 0, 0); chk(0);
    #2 rst = 1'b0;
    exp32("rst_valid", 0, 1, 0, 0); tick(); chk(0);
    jump_en = 1; jump_addr = 'h10;
    exp32("btb_cleared", 'h10, 1, 0, 0); tick(); chk(0);
    jump_en = 0;

    pc_ready_w = 1;
    for (int i = 1; i <= 4; i++) begin
      exp64("seq_w", 64'(i * 4), 1, 0, 0); tick(); chk(1);
    end
    upd_en_w = 1; upd_pc_w = 'h14; upd_target_w = 'h100; upd_taken_w = 1;
    exp64("upd_ignored", 'h14, 1, 0, 0); tick(); chk(1);
    upd_en_w = 0;
    jump_en_w = 1; jump_addr_w = 'h14;
    exp64("no_btb_jump", 'h14, 1, 0, 0); tick(); chk(1);
    jump_en_w = 0;
    exp64("no_btb_seq", 'h18, 1, 0, 0); tick(); chk(1);
    jump_en_w = 1; jump_addr_w = 64'hFFFF_FFFF_FFFF_FFFE;
    exp64("top_mis_w", 64'hFFFF_FFFF_FFFF_FFFC, 1, 0, 1); tick(); chk(1);
    jump_en_w = 0;
    exp64("wrap_w", 0, 1, 0, 0); tick(); chk(1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule

// File: doc/pc_gen.md
# pc_gen

Parametrised program-counter generator for the RISC-V core; successor to the fixed 32-bit PC register. Sits between ctrl and ifetch. Holds the fetch PC and offers it to ifetch over a valid/ready handshake. Advances by 4 per accepted fetch, or to a target supplied by an optional direct-mapped branch target buffer (BTB). Accepts trap and jump redirects from ctrl with fixed priority.

## Interface
- XLEN, 32: address width; must be ≥ 2 + log2(BTB_DEPTH) + 1.
- RESET_ADDR, 0: PC after reset; must be 4-byte aligned.
- BTB_EN, 1: 1 = BTB instantiated; 0 = pure sequential and redirect behaviour.
- BTB_DEPTH, 8: BTB entries; power of two, ≥ 2.

Ports:
- clk  in  1  clock, rising-edge.
- rst  in  1  reset, asynchronous, active-high.
- trap_en_i  in  1  trap redirect request from ctrl.
- trap_addr_i  in  XLEN  trap vector.
- jump_en_i  in  1  branch/jump redirect from ctrl.
- jump_addr_i  in  XLEN  jump target.
- upd_en_i  in  1  BTB update strobe (resolved branch).
- upd_pc_i  in  XLEN  PC of resolved branch.
- upd_target_i  in  XLEN  resolved target.
- upd_taken_i  in  1  resolved direction.
- pc_valid_o  out  1  pc_addr_o is a valid fetch address.
- pc_ready_i  in  1  ifetch accepts pc_addr_o this cycle.
- pc_addr_o  out  XLEN  fetch PC, registered.
- pc_pred_o  out  1  next PC will come from a BTB prediction.
- misalign_o  out  1  one-cycle pulse: a redirect target had bits [1:0] ≠ 0.

## Operation
- Reset values: pc_addr_o = RESET_ADDR; pc_valid_o = 0; misalign_o = 0. All BTB valid bits are 0 and all counters are 0.
- Next-PC priority at each edge, highest first: trap_en_i, then jump_en_i, then accepted fetch (pc_valid_o & pc_ready_i), then hold.
- Redirect (trap or jump): pc_addr_o ← {addr[XLEN-1:2], 2'b00}; pc_valid_o ← 1. Applies regardless of pc_ready_i; an offered PC that was not accepted is dropped.
- misalign_o ← 1 in the cycle after a redirect whose selected address has [1:0] ≠ 0.
- Accepted fetch: pc_addr_o ← BTB target if pc_pred_o, else pc_addr_o + 4. Addition is modulo 2^XLEN (0xFFFF_FFFC + 4 → 0).
- No accept and no redirect: pc_addr_o and pc_valid_o hold.
- BTB entry fields: valid, tag, target[XLEN-1:2], 2-bit saturating counter.
  - Index = pc[IDX+1:2], where IDX = log2(BTB_DEPTH).
  - Tag = pc[XLEN-1:IDX+2].
- Lookup (combinational on pc_addr_o): pc_pred_o = valid & tag match & ctr[1] & pc_valid_o. Forced to 0 when BTB_EN = 0.
- Update, on an edge with upd_en_i:
  - Hit: counter moves +1 on taken, −1 on not-taken, saturating at 3 and 0. Target is rewritten on taken.
  - Miss, taken: allocate the entry (overwrite): valid = 1, tag, target, ctr = 2.
  - Miss, not-taken: no change.
- Lookup and update in the same cycle on the same index: the lookup uses pre-update contents (read-before-write).

## Timing
- Latency from redirect strobe to new pc_addr_o: 1 cycle. The new PC is offered with pc_valid_o = 1 in that cycle.
- pc_valid_o rises at the first clk edge after rst deasserts, with pc_addr_o = RESET_ADDR. It stays 1 thereafter.
- rst asserted mid-operation: outputs take their reset values immediately (asynchronously) and the BTB is cleared.
- A BTB update is visible to lookups from the cycle after the update edge.
- pc_pred_o is combinational from registered state only. There is no combinational path from any input to any output except pc_ready_i → none; pc_ready_i only affects next state.

## Structure
- Shared package riscv_pkg:
  - PC_INC = 4.
  - Counter constants: SNT = 0, WNT = 1, WT = 2, ST = 3.
  - btb_entry_t typedef (valid, tag, target, ctr).
- Sub-module pc_btb:
  - Storage, lookup and update logic.
  - Generated only when BTB_EN = 1.
  - pc_gen keeps the PC register, priority mux and handshake.

## Test plan
- Reset, then hold pc_ready_i = 1 for 4 cycles: pc_addr_o = 0, 4, 8, 0xC with pc_valid_o = 1 and pc_pred_o = 0.
- pc_ready_i = 0 for 3 cycles at PC 0x10: pc_addr_o holds 0x10. Then jump_en_i with 0x203: next pc_addr_o = 0x200 and misalign_o pulses once.
- trap_en_i (0x80) and jump_en_i (0x400) in the same cycle: pc_addr_o = 0x80.
- upd_en_i with pc 0x10, target 0x100, taken; then fetch reaches 0x10: pc_pred_o = 1 and next pc_addr_o = 0x100. Two not-taken updates at 0x10: pc_pred_o = 0 and next PC = 0x14.
- Aliasing with BTB_DEPTH = 8: a taken entry at 0x10 and a lookup at 0x30 (same index, different tag) give pc_pred_o = 0 and next PC = 0x34.
- rst asserted mid-stream at PC 0x44: pc_addr_o = RESET_ADDR immediately, pc_valid_o = 0, and prior BTB entries no longer predict. Repeat the suite with BTB_EN = 0 and XLEN = 64 to confirm sequential behaviour and wrap from 0xFFFF_FFFF_FFFF_FFFC to 0.
